// File: rtl/discrete_audio_pkg.sv
// rtl/discrete_audio_pkg.sv - shared types, widths and saturation helper for the discrete audio chain
package discrete_audio_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic signed [31:0] acc_t;

    localparam int ALPHA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_UPDATE,
        ST_DONE
    } lp_state_t;

    function automatic sample_t sat16(input logic signed [16:0] v);
        if (v > 17'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -17'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/serial_shift_add_multiplier.sv
// rtl/serial_shift_add_multiplier.sv - 17x16 signed-by-unsigned shift-add multiplier, one multiplier bit per clock
module serial_shift_add_multiplier
    import discrete_audio_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [16:0]        multiplicand,
    input  logic        [ALPHA_W-1:0] multiplier,
    output logic signed [32:0]        product,
    output logic                      done
);

    localparam logic [3:0] LAST_IDX = 4'(ALPHA_W - 1);

    logic signed [32:0]  addend;
    logic [ALPHA_W-1:0]  bits;
    logic [3:0]          idx;
    logic                running;

    // done is combinational so the caller sees it during the last iteration,
    // and product is final on the following cycle.
    assign done = running && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            product <= '0;
            addend  <= '0;
            bits    <= '0;
            idx     <= '0;
            running <= 1'b0;
        end else if (start) begin
            product <= '0;
            addend  <= {{16{multiplicand[16]}}, multiplicand};
            bits    <= multiplier;
            idx     <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (bits[0]) begin
                product <= product + addend;
            end
            addend <= addend <<< 1;
            bits   <= bits >> 1;
            idx    <= idx + 4'd1;
            if (idx == LAST_IDX) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rc_lowpass_filter.sv
// rtl/rc_lowpass_filter.sv - first-order RC low-pass y += alpha*(x-y), optional high-pass tap via RC_FILTER_HIGHPASS_EN
module rc_lowpass_filter
    import discrete_audio_pkg::*;
#(
    parameter int unsigned ALPHA = 7581
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    audio_clk_en,
    input  sample_t in,
    output sample_t out,
    output logic    out_valid,
    output logic    busy,
    output logic    overrun
`ifdef RC_FILTER_HIGHPASS_EN
    ,
    output sample_t out_hp
`endif
);

    localparam logic [ALPHA_W-1:0] ALPHA_Q = ALPHA_W'(ALPHA);

    lp_state_t          state;
    acc_t               y_acc;
    logic               accept;
    logic signed [16:0] diff;
    logic signed [32:0] product;
    logic               mul_done;
    logic signed [33:0] sum_wide;
    acc_t               sum_sat;

    assign accept = (state == ST_IDLE) && audio_clk_en;
    assign diff   = {in[15], in} - {out[15], out};

    // The multiplier latches diff on the accepting edge, so it acts as the diff register.
    serial_shift_add_multiplier u_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (accept),
        .multiplicand (diff),
        .multiplier   (ALPHA_Q),
        .product      (product),
        .done         (mul_done)
    );

    assign sum_wide = {{2{y_acc[31]}}, y_acc} + {product[32], product};

    always_comb begin
        sum_sat = sum_wide[31:0];
        if (sum_wide > 34'sh0_7FFF_FFFF) begin
            sum_sat = 32'sh7FFF_FFFF;
        end else if (sum_wide < -34'sh0_8000_0000) begin
            sum_sat = 32'sh8000_0000;
        end
    end

`ifdef RC_FILTER_HIGHPASS_EN
    sample_t x_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            y_acc     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
`ifdef RC_FILTER_HIGHPASS_EN
            x_reg     <= '0;
            out_hp    <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (audio_clk_en) begin
                        state <= ST_MUL;
                        busy  <= 1'b1;
`ifdef RC_FILTER_HIGHPASS_EN
                        x_reg <= in;
`endif
                    end
                end
                ST_MUL: begin
                    if (audio_clk_en) overrun <= 1'b1;
                    if (mul_done) state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (audio_clk_en) overrun <= 1'b1;
                    y_acc     <= sum_sat;
                    out       <= sum_sat[31:16];
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_DONE;
`ifdef RC_FILTER_HIGHPASS_EN
                    out_hp    <= sat16({x_reg[15], x_reg} - {sum_sat[31], sum_sat[31:16]});
`endif
                end
                // One dead cycle on the way back so strobes are at least 19 clocks apart.
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc_lowpass_filter.sv
// tb/tb_rc_lowpass_filter.sv - randomized self-checking bench for rc_lowpass_filter at three alpha settings
module tb_rc_lowpass_filter;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic signed [15:0] in_s;

    logic signed [15:0] out_a, out_b, out_c;
    logic valid_a, valid_b, valid_c;
    logic busy_a, busy_b, busy_c;
    logic ovr_a, ovr_b, ovr_c;
`ifdef RC_FILTER_HIGHPASS_EN
    logic signed [15:0] hp_a, hp_b, hp_c;
`endif

    always #5 clk = ~clk;

    rc_lowpass_filter #(.ALPHA(32768)) dut_a (
        .clk(clk), .reset(reset), .audio_clk_en(en), .in(in_s),
        .out(out_a), .out_valid(valid_a), .busy(busy_a), .overrun(ovr_a)
`ifdef RC_FILTER_HIGHPASS_EN
        , .out_hp(hp_a)
`endif
    );

    rc_lowpass_filter #(.ALPHA(65535)) dut_b (
        .clk(clk), .reset(reset), .audio_clk_en(en), .in(in_s),
        .out(out_b), .out_valid(valid_b), .busy(busy_b), .overrun(ovr_b)
`ifdef RC_FILTER_HIGHPASS_EN
        , .out_hp(hp_b)
`endif
    );

    rc_lowpass_filter dut_c (
        .clk(clk), .reset(reset), .audio_clk_en(en), .in(in_s),
        .out(out_c), .out_valid(valid_c), .busy(busy_c), .overrun(ovr_c)
`ifdef RC_FILTER_HIGHPASS_EN
        , .out_hp(hp_c)
`endif
    );

    int checks = 0;
    int failures = 0;

    longint alpha_m [3] = '{32768, 65535, 7581};
    longint y_m [3];
    longint hp_m [3];
    bit     ov_m;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat_m(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Real-number filter step on a Q16.16 integer: floor output, exact product, clamp to 32 bits.
    function automatic longint step_m(input longint y, input longint a, input longint x);
        longint s;
        s = y + (x - (y >>> 16)) * a;
        if (s > 64'sh7FFF_FFFF) s = 64'sh7FFF_FFFF;
        if (s < -64'sh8000_0000) s = -64'sh8000_0000;
        return s;
    endfunction

    task automatic model_update(input longint x);
        for (int i = 0; i < 3; i++) begin
            y_m[i]  = step_m(y_m[i], alpha_m[i], x);
            hp_m[i] = sat_m(x - (y_m[i] >>> 16));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            y_m[i]  = 0;
            hp_m[i] = 0;
        end
        ov_m = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_out_a"}, out_a, y_m[0] >>> 16);
        check_eq({tag, "_out_b"}, out_b, y_m[1] >>> 16);
        check_eq({tag, "_out_c"}, out_c, y_m[2] >>> 16);
`ifdef RC_FILTER_HIGHPASS_EN
        check_eq({tag, "_hp_a"}, hp_a, hp_m[0]);
        check_eq({tag, "_hp_b"}, hp_b, hp_m[1]);
        check_eq({tag, "_hp_c"}, hp_c, hp_m[2]);
`endif
    endtask

    // Strobe once with x in cycle 0, scramble in afterwards, optionally strobe again in cycle extra.
    task automatic run_update(input logic signed [15:0] x, input int extra);
        logic [18:0] bm;
        logic [18:0] vm;
        bm = '0;
        vm = '0;
        @(negedge clk);
        in_s = x;
        en   = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            bm[k] = busy_c;
            vm[k] = valid_c;
            in_s  = 16'($urandom);
            en    = (k == extra);
            if (k == extra && k <= 17) ov_m = 1'b1;
        end
        model_update(longint'(x));
        check_eq("busy_window", bm, 19'h3FFFE);
        check_eq("valid_window", vm, 19'h40000);
        check_outputs("upd");
        check_eq("overrun", ovr_c, ov_m);
    endtask

    initial begin
        longint step_exp [4] = '{8192, 12288, 14336, 15360};
        longint hp_exp [3]   = '{8192, 4096, 2048};
        logic signed [15:0] x;
        int pulses, bad_pos;
        bit vseen, bseen;

        reset = 1'b1;
        en    = 1'b1;
        in_s  = 16'sd1234;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_out", out_c, 0);
        check_eq("rst_valid", valid_c, 0);
        check_eq("rst_busy", busy_c, 0);
        check_eq("rst_overrun", ovr_c, 0);
        reset = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        check_eq("strobe_in_reset", busy_c, 0);

        for (int i = 0; i < 4; i++) begin
            run_update(16'sd16384, 0);
            check_eq("step_const", out_a, step_exp[i]);
`ifdef RC_FILTER_HIGHPASS_EN
            if (i < 3) check_eq("hp_const", hp_a, hp_exp[i]);
`endif
        end

        for (int i = 0; i < 12; i++) begin
            x = 16'($urandom);
            run_update(x, 0);
        end

        run_update(16'($urandom), 5);
        check_eq("overrun_sticky", ovr_c, 1);

        x = 16'($urandom);
        pulses  = 0;
        bad_pos = 0;
        @(negedge clk);
        in_s = x;
        en   = 1'b1;
        for (int k = 1; k <= 57; k++) begin
            @(negedge clk);
            if (valid_c) begin
                pulses++;
                if (k % 19 != 18) bad_pos++;
                model_update(longint'(x));
                check_outputs("held");
            end
            if (k == 57) en = 1'b0;
        end
        ov_m = 1'b1;
        check_eq("held_pulses", pulses, 3);
        check_eq("held_pulse_pos", bad_pos, 0);
        check_eq("held_overrun", ovr_c, ov_m);

        vseen = 1'b0;
        bseen = 1'b0;
        @(negedge clk);
        in_s = 16'sd1000;
        en   = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (valid_c) vseen = 1'b1;
            if (k >= 11 && busy_c) bseen = 1'b1;
            en    = 1'b0;
            reset = (k == 10);
        end
        model_reset();
        check_eq("abort_valid", vseen, 0);
        check_eq("abort_busy", bseen, 0);
        check_eq("abort_overrun", ovr_c, 0);
        check_outputs("abort");

        run_update(-16'sd32768, 0);
        check_eq("negfs_const", out_b, -32768);
        run_update(-16'sd32768, 0);
        check_eq("negfs_hold", out_b, -32768);

        run_update(out_c, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
